// File: rtl/mem_access_pkg.sv
// Shared types and widths for the MEM-stage memory access controller.
// The optional hit/miss statistics are enabled with MEM_ACCESS_STATS_EN.
package mem_access_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WD_W   = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_stats.sv
// Saturating cache hit/miss counters, only built when MEM_ACCESS_STATS_EN is defined.
module mem_access_stats
  import mem_access_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_i,
  input  logic             miss_i,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] miss_count_o
);

  logic [1:0]            inc;
  logic [1:0][CNT_W-1:0] cnt;

  assign inc = {miss_i, hit_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Hold at all-ones rather than wrapping back to zero.
    always_comb begin
      cnt_d = cnt_q;
      if (inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt[gi] = cnt_q;
  end

  assign hit_count_o  = cnt[0];
  assign miss_count_o = cnt[1];

endmodule

// File: rtl/mem_access_ctrl.sv
// Pipeline-side initiator for mem_system: one access at a time, misalignment reject, watchdog.
// Define MEM_ACCESS_STATS_EN to build the hit/miss counters; otherwise the count ports read 0.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              pipe_stall,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] DataIn,
  output logic              Rd,
  output logic              Wr,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              Done,
  input  logic              Stall,
  input  logic              CacheHit,
  input  logic              err,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WD_W-1:0]   wd_q;
  logic              rd_q, wr_q, err_q;
  logic              aligned, busy_done, timeout;

  // Stall only reports memory-side occupancy; completion is signalled by Done.
  logic unused_inputs;
  assign unused_inputs = ^{Stall, CacheHit};

  assign aligned   = ~req_addr[0];
  assign busy_done = (state_q == ST_BUSY) & Done;
  // Done in the last watchdog cycle is still a clean completion.
  assign timeout   = (state_q == ST_BUSY) & ~Done & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = aligned ? ST_BUSY : ST_RESP;
      ST_BUSY: if (busy_done || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    pipe_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready  = 1'b1;
        pipe_stall = req_valid;
      end
      ST_BUSY: pipe_stall = 1'b1;
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      wd_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && aligned) begin
            addr_q <= req_addr;
            data_q <= req_wdata;
            rd_q   <= ~req_wr;
            wr_q   <= req_wr;
            wd_q   <= '0;
            err_q  <= 1'b0;
          end else if (req_valid) begin
            err_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Any err seen while the strobe is up taints the whole access.
          err_q <= err_q | err | timeout;
          wd_q  <= wd_q + 1'b1;
          if (Done && rd_q) rdata_q <= DataOut;
          if (Done || timeout) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Addr       = addr_q;
  assign DataIn     = data_q;
  assign Rd         = rd_q;
  assign Wr         = wr_q;
  assign resp_rdata = rdata_q;

`ifdef MEM_ACCESS_STATS_EN
  mem_access_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .hit_i        (busy_done & CacheHit),
    .miss_i       (busy_done & ~CacheHit),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver plays the memory system, monitor checks responses.
module tb_mem_access_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, pipe_stall;
  logic [15:0] resp_rdata, Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit, err;
  logic [15:0] hit_count, miss_count;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_rdata = 16'h0;
  int          m_hits = 0;
  int          m_miss = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .pipe_stall(pipe_stall),
    .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_hits();
`ifdef MEM_ACCESS_STATS_EN
    return m_hits;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_miss();
`ifdef MEM_ACCESS_STATS_EN
    return m_miss;
`else
    return 0;
`endif
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // lat = cycle (1-based after accept) in which Done is driven; 0 or > T means never.
  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input int lat, input logic hit, input int err_cyc, input logic [15:0] rdat);
    exp_t e;
    int   base, done_at, last;
    wait_ready();
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    Done = 1'b0; err = 1'b0; CacheHit = 1'b0;
    #1;
    chk("stall_on_req", {31'd0, pipe_stall}, 32'd1);
    base    = cyc;
    done_at = (lat >= 1 && lat <= T) ? lat : 0;
    if (addr[0]) begin
      e.err = 1'b1; e.rdata = m_rdata; e.cyc = base + 1;
    end else if (done_at == 0) begin
      e.err = 1'b1; e.rdata = m_rdata; e.cyc = base + T + 1;
    end else begin
      e.err = (err_cyc >= 1 && err_cyc <= done_at);
      if (!wr) m_rdata = rdat;
      e.rdata = m_rdata;
      e.cyc = base + done_at + 1;
      if (hit) m_hits++; else m_miss++;
    end
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (!addr[0]) begin
      last = (done_at == 0) ? T : done_at;
      for (int k = 1; k <= last; k++) begin
        chk("rd_busy", {31'd0, Rd}, {31'd0, ~wr});
        chk("wr_busy", {31'd0, Wr}, {31'd0, wr});
        chk("addr_hold", {16'd0, Addr}, {16'd0, addr});
        chk("datain_hold", {16'd0, DataIn}, {16'd0, wdata});
        chk("stall_busy", {31'd0, pipe_stall}, 32'd1);
        Done     = (k == done_at);
        err      = (k == err_cyc);
        CacheHit = (k == done_at) ? hit : 1'($urandom);
        DataOut  = (k == done_at) ? rdat : 16'($urandom);
        @(negedge clk);
      end
    end
    Done = 1'b0; err = 1'b0;
    chk("rd_resp", {31'd0, Rd}, 32'd0);
    chk("wr_resp", {31'd0, Wr}, 32'd0);
    chk("stall_resp", {31'd0, pipe_stall}, 32'd0);
    chk("ready_resp", {31'd0, req_ready}, 32'd0);
    chk("hit_count", {16'd0, hit_count}, exp_hits());
    chk("miss_count", {16'd0, miss_count}, exp_miss());
    $display("txn wr=%0d addr=%04h lat=%0d err_cyc=%0d -> exp err=%0d rdata=%04h at cycle %0d",
             wr, addr, lat, err_cyc, e.err, e.rdata, e.cyc);
  endtask

  // Memory-side noise while idle must have no effect.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Done = 1'($urandom); err = 1'($urandom); CacheHit = 1'($urandom);
      DataOut = 16'($urandom);
    end
    Done = 1'b0; err = 1'b0;
  endtask

  task automatic do_reset_mid();
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0040; req_wdata = 16'h0;
    Done = 1'b0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_rd_c1", {31'd0, Rd}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rdata = 16'h0; m_hits = 0; m_miss = 0;
    chk("rst_mid_rd", {31'd0, Rd}, 32'd0);
    chk("rst_mid_wr", {31'd0, Wr}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_addr", {16'd0, Addr}, 32'd0);
    chk("rst_mid_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst_mid_hits", {16'd0, hit_count}, 32'd0);
    chk("rst_mid_miss", {16'd0, miss_count}, 32'd0);
    repeat (12) @(negedge clk);
    $display("txn reset mid-BUSY at addr 0040 -> no response expected");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    DataOut = '0; Done = 1'b0; Stall = 1'b0; CacheHit = 1'b0; err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst_addr", {16'd0, Addr}, 32'd0);
    chk("rst_datain", {16'd0, DataIn}, 32'd0);
    chk("rst_rdwr", {30'd0, Rd, Wr}, 32'd0);
    chk("rst_hits", {16'd0, hit_count}, 32'd0);
    chk("rst_miss", {16'd0, miss_count}, 32'd0);
    rst = 1'b0;

    do_txn(1'b0, 16'h0010, 16'h0000, 1, 1'b1, 0, 16'hBEEF);
    do_txn(1'b1, 16'h0200, 16'h1234, 5, 1'b0, 0, 16'h0000);
    do_txn(1'b0, 16'h0003, 16'h0000, 1, 1'b1, 0, 16'h5555);
    do_txn(1'b0, 16'h0100, 16'h0000, 0, 1'b0, 0, 16'h0000);
    do_txn(1'b0, 16'h0102, 16'h0000, T, 1'b1, 0, 16'hA5A5);
    do_txn(1'b0, 16'h0104, 16'h0000, 4, 1'b1, 2, 16'hCAFE);
    do_reset_mid();

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      a[0] = ($urandom_range(0, 4) == 0);
      idle_noise($urandom_range(0, 3));
      do_txn(1'($urandom), a, 16'($urandom), $urandom_range(0, 10), 1'($urandom),
             $urandom_range(0, 10), 16'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
